// File: rtl/cmp_share_ctrl_if.sv
// ---------------------------------------------------------------------------
// cmp_share_ctrl_if
// Bundle of signals between the compare-issuing requesters, the shared-
// comparator sequencer (cmp_share_ctrl) and the single comparator instance.
//
// Parameters: WIDTH (operand width), NREQ (requester count), IDW (id width).
//
// Signals:
//   req        requester -> ctrl   level request per requester
//   op_a/op_b  requester -> ctrl   flattened operands, requester i at [i*WIDTH +: WIDTH]
//   grant      ctrl -> requester   one-hot served requester (ISSUE..RESP)
//   done       ctrl -> requester   one-cycle result-valid pulse
//   res_id     ctrl -> requester   index of the served requester
//   res_eq/gt/lt/err               registered comparator flags and error flag
//   busy       ctrl -> requester   high while an operation is in flight
//   cmp_a/cmp_b/cmp_enable         ctrl -> comparator
//   cmp_eq/cmp_gt/cmp_lt           comparator -> ctrl
//
// Modports: slave is the controller's view, master is the environment's view
// (requesters plus comparator).
// ---------------------------------------------------------------------------
interface cmp_share_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] op_a;
    logic [NREQ*WIDTH-1:0] op_b;
    logic [NREQ-1:0]       grant;
    logic                  done;
    logic [IDW-1:0]        res_id;
    logic                  res_eq;
    logic                  res_gt;
    logic                  res_lt;
    logic                  res_err;
    logic                  busy;
    logic [WIDTH-1:0]      cmp_a;
    logic [WIDTH-1:0]      cmp_b;
    logic                  cmp_enable;
    logic                  cmp_eq;
    logic                  cmp_gt;
    logic                  cmp_lt;

    modport slave (
        input  req, op_a, op_b, cmp_eq, cmp_gt, cmp_lt,
        output grant, done, res_id, res_eq, res_gt, res_lt, res_err, busy,
               cmp_a, cmp_b, cmp_enable
    );

    modport master (
        output req, op_a, op_b, cmp_eq, cmp_gt, cmp_lt,
        input  grant, done, res_id, res_eq, res_gt, res_lt, res_err, busy,
               cmp_a, cmp_b, cmp_enable
    );
endinterface

// File: rtl/cmp_share_ctrl.sv
// ---------------------------------------------------------------------------
// cmp_share_ctrl
// Time-shares one external magnitude comparator among NREQ requesters.
// A winner is picked in IDLE, its operands and id are latched, the comparator
// is driven for one cycle (ISSUE), the flags are registered and returned with
// a one-cycle done pulse (RESP). One compare every three cycles.
//
// Ports:
//   clk   clock, all state changes on the rising edge
//   rst   synchronous active-high reset, overrides everything
//   bus   cmp_share_ctrl_if.slave: requester handshake, results and the
//         comparator drive/return signals
//
// Build option: macro CMP_SHARE_RR_EN selects round-robin arbitration
// starting at a rotating pointer; without it the lowest requesting index
// wins and no pointer exists.
// ---------------------------------------------------------------------------
module cmp_share_ctrl #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic             clk,
    input  logic             rst,
    cmp_share_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [NREQ-1:0]  grant_reg;
    logic             done_reg;
    logic [IDW-1:0]   res_id_reg;
    logic             res_eq_reg;
    logic             res_gt_reg;
    logic             res_lt_reg;
    logic             res_err_reg;
    logic             busy_reg;
    logic [WIDTH-1:0] cmp_a_reg;
    logic [WIDTH-1:0] cmp_b_reg;
    logic             cmp_enable_reg;

    // Unpacked views of the flattened operand buses.
    logic [WIDTH-1:0] a_slice [NREQ];
    logic [WIDTH-1:0] b_slice [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slice
            assign a_slice[gi] = bus.op_a[gi*WIDTH +: WIDTH];
            assign b_slice[gi] = bus.op_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    logic [IDW-1:0]  win_id;
    logic [NREQ-1:0] win_onehot;

`ifdef CMP_SHARE_RR_EN
    logic [IDW-1:0] ptr_reg;
    logic [IDW-1:0] ptr_next;
    logic           found;
    int             idx;

    // Scan upward from the pointer, wrapping at NREQ-1, first request wins.
    always_comb begin
        win_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && bus.req[IDW'(idx)]) begin
                found  = 1'b1;
                win_id = IDW'(idx);
            end
        end
    end

    // Next search starts just after the requester served now.
    assign ptr_next = (res_id_reg == IDW'(NREQ-1)) ? '0 : res_id_reg + 1'b1;
`else
    // Fixed priority: iterate downward so the lowest set index is kept last.
    always_comb begin
        win_id = '0;
        for (int k = NREQ-1; k >= 0; k--) begin
            if (bus.req[IDW'(k)]) begin
                win_id = IDW'(k);
            end
        end
    end
`endif

    always_comb begin
        win_onehot         = '0;
        win_onehot[win_id] = 1'b1;
    end

    // Flags are valid only when exactly one of eq/gt/lt is set.
    logic flags_onehot;
    assign flags_onehot = ( bus.cmp_eq & ~bus.cmp_gt & ~bus.cmp_lt) |
                          (~bus.cmp_eq &  bus.cmp_gt & ~bus.cmp_lt) |
                          (~bus.cmp_eq & ~bus.cmp_gt &  bus.cmp_lt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            done_reg       <= 1'b0;
            res_id_reg     <= '0;
            res_eq_reg     <= 1'b0;
            res_gt_reg     <= 1'b0;
            res_lt_reg     <= 1'b0;
            res_err_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            cmp_a_reg      <= '0;
            cmp_b_reg      <= '0;
            cmp_enable_reg <= 1'b0;
`ifdef CMP_SHARE_RR_EN
            ptr_reg        <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (|bus.req) begin
                        // Operands and id are captured here, so later
                        // changes on the request side cannot disturb the
                        // operation in flight.
                        grant_reg      <= win_onehot;
                        res_id_reg     <= win_id;
                        cmp_a_reg      <= a_slice[win_id];
                        cmp_b_reg      <= b_slice[win_id];
                        cmp_enable_reg <= 1'b1;
                        busy_reg       <= 1'b1;
                        state_reg      <= ISSUE;
                    end
                end
                ISSUE: begin
                    res_eq_reg     <= bus.cmp_eq;
                    res_gt_reg     <= bus.cmp_gt;
                    res_lt_reg     <= bus.cmp_lt;
                    res_err_reg    <= ~flags_onehot;
                    cmp_enable_reg <= 1'b0;
                    cmp_a_reg      <= '0;
                    cmp_b_reg      <= '0;
                    done_reg       <= 1'b1;
                    state_reg      <= RESP;
                end
                RESP: begin
                    done_reg  <= 1'b0;
                    grant_reg <= '0;
                    busy_reg  <= 1'b0;
`ifdef CMP_SHARE_RR_EN
                    ptr_reg   <= ptr_next;
`endif
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant      = grant_reg;
    assign bus.done       = done_reg;
    assign bus.res_id     = res_id_reg;
    assign bus.res_eq     = res_eq_reg;
    assign bus.res_gt     = res_gt_reg;
    assign bus.res_lt     = res_lt_reg;
    assign bus.res_err    = res_err_reg;
    assign bus.busy       = busy_reg;
    assign bus.cmp_a      = cmp_a_reg;
    assign bus.cmp_b      = cmp_b_reg;
    assign bus.cmp_enable = cmp_enable_reg;

endmodule

// File: tb/tb_cmp_share_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cmp_share_ctrl
// Self-checking bench for cmp_share_ctrl: behavioural comparator, arbitration
// reference model, directed scenarios plus randomized transactions.
// Follows the CMP_SHARE_RR_EN macro for the expected arbitration order.
// ---------------------------------------------------------------------------
module tb_cmp_share_ctrl;
    localparam int WIDTH = 4;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int OPW   = NREQ * WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cmp_share_ctrl_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus_i ();

    cmp_share_ctrl #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_i)
    );

    int n_checks   = 0;
    int n_fail     = 0;
    int ptr_m      = 0;
    int force_mode = 0;   // 0 normal, 1 gt=lt=1, 2 all flags 0

    // Behavioural comparator; a disabled comparator reports eq.
    always_comb begin
        if (force_mode == 1) begin
            bus_i.cmp_eq = 1'b0; bus_i.cmp_gt = 1'b1; bus_i.cmp_lt = 1'b1;
        end else if (force_mode == 2) begin
            bus_i.cmp_eq = 1'b0; bus_i.cmp_gt = 1'b0; bus_i.cmp_lt = 1'b0;
        end else if (bus_i.cmp_enable) begin
            bus_i.cmp_eq = (bus_i.cmp_a == bus_i.cmp_b);
            bus_i.cmp_gt = (bus_i.cmp_a >  bus_i.cmp_b);
            bus_i.cmp_lt = (bus_i.cmp_a <  bus_i.cmp_b);
        end else begin
            bus_i.cmp_eq = 1'b1; bus_i.cmp_gt = 1'b0; bus_i.cmp_lt = 1'b0;
        end
    end

    // Reference arbitration: first requester found from the pointer
    // (round-robin) or from index 0 (fixed priority).
    function automatic int pick(input logic [NREQ-1:0] r);
        for (int k = 0; k < NREQ; k++) begin
`ifdef CMP_SHARE_RR_EN
            int i = (ptr_m + k) % NREQ;
`else
            int i = k;
`endif
            if (r[i]) return i;
        end
        return -1;
    endfunction

    // Expected {eq, gt, lt, err} for operands under the current force mode.
    function automatic logic [3:0] exp_flags(input int a, input int b);
        if (force_mode == 1) return 4'b0111;
        if (force_mode == 2) return 4'b0001;
        return {a == b, a > b, a < b, 1'b0};
    endfunction

    // One complete transaction starting from IDLE, checked cycle by cycle.
    task automatic run_op(input string tag, input logic [NREQ-1:0] r,
                          input logic [OPW-1:0] a, input logic [OPW-1:0] b);
        int w;
        int ea, eb;
        logic [NREQ-1:0] eg;
        logic [3:0] ef, got_f;
        @(negedge clk);
        bus_i.req = r; bus_i.op_a = a; bus_i.op_b = b;
        w  = pick(r);
        ea = int'(a[w*WIDTH +: WIDTH]);
        eb = int'(b[w*WIDTH +: WIDTH]);
        eg = '0; eg[w] = 1'b1;
        ef = exp_flags(ea, eb);
        @(negedge clk);   // ISSUE
        n_checks++;
        if (bus_i.grant !== eg) begin
            n_fail++; $display("FAIL %s issue_grant: got %b expected %b", tag, bus_i.grant, eg);
        end
        n_checks++;
        if ({bus_i.busy, bus_i.cmp_enable, bus_i.done} !== 3'b110) begin
            n_fail++; $display("FAIL %s issue_ctrl {busy,en,done}: got %b expected 110", tag,
                               {bus_i.busy, bus_i.cmp_enable, bus_i.done});
        end
        n_checks++;
        if (bus_i.cmp_a !== WIDTH'(ea) || bus_i.cmp_b !== WIDTH'(eb)) begin
            n_fail++; $display("FAIL %s issue_operands: got a=%0d b=%0d expected a=%0d b=%0d", tag,
                               bus_i.cmp_a, bus_i.cmp_b, ea, eb);
        end
        // Operand changes mid-flight must not matter.
        bus_i.op_a = OPW'($urandom); bus_i.op_b = OPW'($urandom);
        @(negedge clk);   // RESP
        got_f = {bus_i.res_eq, bus_i.res_gt, bus_i.res_lt, bus_i.res_err};
        n_checks++;
        if (bus_i.done !== 1'b1 || bus_i.busy !== 1'b1 || bus_i.cmp_enable !== 1'b0) begin
            n_fail++; $display("FAIL %s resp_ctrl {done,busy,en}: got %b expected 110", tag,
                               {bus_i.done, bus_i.busy, bus_i.cmp_enable});
        end
        n_checks++;
        if (bus_i.res_id !== IDW'(w) || bus_i.grant !== eg) begin
            n_fail++; $display("FAIL %s resp_id: got id=%0d grant=%b expected id=%0d grant=%b", tag,
                               bus_i.res_id, bus_i.grant, w, eg);
        end
        n_checks++;
        if (got_f !== ef) begin
            n_fail++; $display("FAIL %s resp_flags {eq,gt,lt,err}: got %b expected %b", tag, got_f, ef);
        end
        bus_i.req = '0;
        ptr_m = (w + 1) % NREQ;
        @(negedge clk);   // back in IDLE
        n_checks++;
        if ({bus_i.done, bus_i.busy, bus_i.grant} !== '0) begin
            n_fail++; $display("FAIL %s idle_after: got {done,busy,grant}=%b expected 0", tag,
                               {bus_i.done, bus_i.busy, bus_i.grant});
        end
        $display("op %s req=%b id=%0d a=%0d b=%0d flags=%b", tag, r, w, ea, eb, got_f);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; bus_i.req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ptr_m = 0;
    endtask

    task automatic test_reset();
        bus_i.req  = 4'b1111;
        bus_i.op_a = OPW'($urandom);
        bus_i.op_b = OPW'($urandom);
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if ({bus_i.grant, bus_i.done, bus_i.res_id, bus_i.res_eq, bus_i.res_gt, bus_i.res_lt,
                 bus_i.res_err, bus_i.busy, bus_i.cmp_a, bus_i.cmp_b, bus_i.cmp_enable} !== '0) begin
                n_fail++; $display("FAIL reset_outputs cycle %0d: got grant=%b done=%b busy=%b en=%b id=%0d expected all 0",
                                   c, bus_i.grant, bus_i.done, bus_i.busy, bus_i.cmp_enable, bus_i.res_id);
            end
        end
        rst = 1'b0;
        ptr_m = 0;
        @(negedge clk);
        n_checks++;
        if (bus_i.grant !== 4'b0001) begin
            n_fail++; $display("FAIL reset_first_grant: got %b expected 0001", bus_i.grant);
        end
        @(negedge clk);
        n_checks++;
        if (bus_i.done !== 1'b1 || bus_i.res_id !== 2'd0) begin
            n_fail++; $display("FAIL reset_first_done: got done=%b id=%0d expected done=1 id=0",
                               bus_i.done, bus_i.res_id);
        end
        bus_i.req = '0;
        ptr_m = 1;
        @(negedge clk);
        $display("reset test done");
    endtask

    task automatic test_basic();
        logic [OPW-1:0] a, b;
        a = OPW'($urandom); b = OPW'($urandom);
        a[3:0] = 4'd9; b[3:0] = 4'd3;
        run_op("gt_req0", 4'b0001, a, b);
        a = OPW'($urandom); b = OPW'($urandom);
        a[11:8] = 4'd15; b[11:8] = 4'd15;
        run_op("eq_req2", 4'b0100, a, b);
        a = OPW'($urandom); b = OPW'($urandom);
        a[7:4] = 4'd0; b[7:4] = 4'd15;
        run_op("lt_req1", 4'b0010, a, b);
    endtask

    task automatic test_back_to_back();
        logic [OPW-1:0] a, b;
        int w, waited;
        bit got;
        logic [3:0] ef, got_f;
        do_reset();
        a = OPW'($urandom); b = OPW'($urandom);
        @(negedge clk);
        bus_i.req = 4'b1111; bus_i.op_a = a; bus_i.op_b = b;
        for (int n = 0; n < 5; n++) begin
            w  = pick(4'b1111);
            ef = exp_flags(int'(a[w*WIDTH +: WIDTH]), int'(b[w*WIDTH +: WIDTH]));
            waited = 0; got = 1'b0;
            while (!got && waited < 6) begin
                @(negedge clk);
                waited++;
                if (bus_i.done === 1'b1) got = 1'b1;
            end
            n_checks++;
            if (!got) begin
                n_fail++; $display("FAIL b2b_done_timeout op %0d: got no done in %0d cycles expected done", n, waited);
            end else begin
                got_f = {bus_i.res_eq, bus_i.res_gt, bus_i.res_lt, bus_i.res_err};
                if (bus_i.res_id !== IDW'(w) || got_f !== ef || (n > 0 && waited != 3)) begin
                    n_fail++; $display("FAIL b2b op %0d: got id=%0d flags=%b gap=%0d expected id=%0d flags=%b gap=3",
                                       n, bus_i.res_id, got_f, waited, w, ef);
                end
                $display("b2b op %0d id=%0d gap=%0d flags=%b", n, bus_i.res_id, waited, got_f);
            end
            ptr_m = (w + 1) % NREQ;
        end
        bus_i.req = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus_i.busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_drain busy: got %b expected 0", bus_i.busy);
        end
    endtask

    task automatic test_abort();
        logic [OPW-1:0] a, b;
        a = OPW'($urandom); b = OPW'($urandom);
        @(negedge clk);
        bus_i.req = 4'b1000; bus_i.op_a = a; bus_i.op_b = b;
        @(negedge clk);
        n_checks++;
        if (bus_i.cmp_enable !== 1'b1 || bus_i.grant !== 4'b1000) begin
            n_fail++; $display("FAIL abort_issue: got en=%b grant=%b expected en=1 grant=1000",
                               bus_i.cmp_enable, bus_i.grant);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus_i.done, bus_i.busy, bus_i.grant, bus_i.cmp_enable} !== '0) begin
            n_fail++; $display("FAIL abort_cleared: got done=%b busy=%b grant=%b en=%b expected all 0",
                               bus_i.done, bus_i.busy, bus_i.grant, bus_i.cmp_enable);
        end
        rst = 1'b0; bus_i.req = '0; ptr_m = 0;
        @(negedge clk);
        n_checks++;
        if (bus_i.done !== 1'b0) begin
            n_fail++; $display("FAIL abort_no_done: got %b expected 0", bus_i.done);
        end
        $display("abort test: operation on req3 cancelled");
        run_op("reissue_req3", 4'b1000, a, b);
    endtask

    task automatic test_err();
        force_mode = 1;
        run_op("err_gt_lt", NREQ'($urandom_range(1, 15)), OPW'($urandom), OPW'($urandom));
        force_mode = 2;
        run_op("err_none", NREQ'($urandom_range(1, 15)), OPW'($urandom), OPW'($urandom));
        force_mode = 0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            run_op($sformatf("rnd%0d", n), NREQ'($urandom_range(1, 15)),
                   OPW'($urandom), OPW'($urandom));
        end
    endtask

    initial begin
        bus_i.req  = '0;
        bus_i.op_a = '0;
        bus_i.op_b = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_abort();
        test_err();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
